// File: rtl/instr_decode_issue.sv
// ---------------------------------------------------------------------------
// instr_decode_issue
//
// Decode/issue stage sitting directly in front of the register file. Accepts
// one RV32I instruction per valid/ready handshake, decodes it into register
// file control, issues it for exactly one cycle and then holds the decoded
// fields until the regfile/ALU side acknowledges with op_done. A watchdog
// aborts an operation whose acknowledge never arrives and raises a sticky
// error flag.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous, active-high reset
//   instr_valid    upstream instruction valid
//   instr_data     32-bit instruction word
//   instr_ready    decoder can accept an instruction
//   rs_addr_valid  one-cycle issue strobe to the register file
//   rs1_rs2_rd     packed addresses {rd, rs2, rs1}
//   imme_data      sign-extended immediate
//   use_imm        ALU operand B is imme_data (1) or rs2 data (0)
//   rs_store       operation is a store
//   rd_wr_en       result is written back to rd
//   alu_op         ALU operation code
//   op_done        completion acknowledge from regfile/ALU
//   illegal_instr  one-cycle pulse when an unsupported opcode is rejected
//   timeout_err    sticky watchdog error, cleared only by rst
// ---------------------------------------------------------------------------
module instr_decode_issue #(
    parameter int BUS_WIDTH      = 32,
    parameter int ADDR_WIDTH     = 15,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    input  logic [31:0]           instr_data,
    output logic                  instr_ready,
    output logic                  rs_addr_valid,
    output logic [ADDR_WIDTH-1:0] rs1_rs2_rd,
    output logic [BUS_WIDTH-1:0]  imme_data,
    output logic                  use_imm,
    output logic                  rs_store,
    output logic                  rd_wr_en,
    output logic [3:0]            alu_op,
    input  logic                  op_done,
    output logic                  illegal_instr,
    output logic                  timeout_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Counter only needs to hold 0..TIMEOUT_CYCLES-1: the expiry decision is
    // made while it still shows the previous count.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_instr_ready;
    logic                  r_rs_addr_valid;
    logic [ADDR_WIDTH-1:0] r_rs1_rs2_rd;
    logic [BUS_WIDTH-1:0]  r_imme_data;
    logic                  r_use_imm;
    logic                  r_rs_store;
    logic                  r_rd_wr_en;
    logic [3:0]            r_alu_op;
    logic                  r_illegal_instr;
    logic                  r_timeout_err;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    logic        w_legal;
    logic [4:0]  w_d_rs1;
    logic [4:0]  w_d_rs2;
    logic [4:0]  w_d_rd;
    logic [31:0] w_d_imm;
    logic        w_d_use_imm;
    logic        w_d_store;
    logic        w_d_wr_en;
    logic [3:0]  w_d_alu;

    assign w_opcode = instr_data[6:0];
    assign w_funct3 = instr_data[14:12];

    assign w_imm_i = {{20{instr_data[31]}}, instr_data[31:20]};
    assign w_imm_s = {{20{instr_data[31]}}, instr_data[31:25], instr_data[11:7]};
    assign w_imm_b = {{19{instr_data[31]}}, instr_data[31], instr_data[7],
                      instr_data[30:25], instr_data[11:8], 1'b0};
    assign w_imm_u = {instr_data[31:12], 12'b0};
    assign w_imm_j = {{11{instr_data[31]}}, instr_data[31], instr_data[19:12],
                      instr_data[20], instr_data[30:21], 1'b0};

    // Register fields a format does not use are forced to x0 so the packed
    // address bus never carries stray instruction bits.
    always_comb begin
        w_legal     = 1'b1;
        w_d_rs1     = '0;
        w_d_rs2     = '0;
        w_d_rd      = '0;
        w_d_imm     = '0;
        w_d_use_imm = 1'b0;
        w_d_store   = 1'b0;
        w_d_alu     = '0;
        case (w_opcode)
            OP_R: begin
                w_d_rs1 = instr_data[19:15];
                w_d_rs2 = instr_data[24:20];
                w_d_rd  = instr_data[11:7];
                w_d_alu = {instr_data[30], w_funct3};
            end
            OP_IMM: begin
                w_d_rs1     = instr_data[19:15];
                w_d_rd      = instr_data[11:7];
                w_d_imm     = w_imm_i;
                w_d_use_imm = 1'b1;
                // Only shift-right uses bit 30 (SRLI/SRAI); elsewhere it is immediate data.
                w_d_alu     = {(w_funct3 == 3'b101) ? instr_data[30] : 1'b0, w_funct3};
            end
            OP_LOAD, OP_JALR: begin
                w_d_rs1     = instr_data[19:15];
                w_d_rd      = instr_data[11:7];
                w_d_imm     = w_imm_i;
                w_d_use_imm = 1'b1;
            end
            OP_STORE: begin
                w_d_rs1     = instr_data[19:15];
                w_d_rs2     = instr_data[24:20];
                w_d_imm     = w_imm_s;
                w_d_use_imm = 1'b1;
                w_d_store   = 1'b1;
            end
            OP_BRANCH: begin
                w_d_rs1 = instr_data[19:15];
                w_d_rs2 = instr_data[24:20];
                w_d_imm = w_imm_b;
                w_d_alu = 4'b1000;
            end
            OP_LUI, OP_AUIPC: begin
                w_d_rd      = instr_data[11:7];
                w_d_imm     = w_imm_u;
                w_d_use_imm = 1'b1;
            end
            OP_JAL: begin
                w_d_rd      = instr_data[11:7];
                w_d_imm     = w_imm_j;
                w_d_use_imm = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Formats without an rd field leave w_d_rd at x0, so this also clears
    // the write enable for stores and branches.
    assign w_d_wr_en = (w_d_rd != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_instr_ready   <= 1'b0;
            r_rs_addr_valid <= 1'b0;
            r_rs1_rs2_rd    <= '0;
            r_imme_data     <= '0;
            r_use_imm       <= 1'b0;
            r_rs_store      <= 1'b0;
            r_rd_wr_en      <= 1'b0;
            r_alu_op        <= '0;
            r_illegal_instr <= 1'b0;
            r_timeout_err   <= 1'b0;
        end else begin
            r_rs_addr_valid <= 1'b0;
            r_illegal_instr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_instr_ready <= 1'b1;
                    if (instr_valid && r_instr_ready) begin
                        if (w_legal) begin
                            r_rs1_rs2_rd    <= {w_d_rd, w_d_rs2, w_d_rs1};
                            r_imme_data     <= w_d_imm;
                            r_use_imm       <= w_d_use_imm;
                            r_rs_store      <= w_d_store;
                            r_rd_wr_en      <= w_d_wr_en;
                            r_alu_op        <= w_d_alu;
                            r_rs_addr_valid <= 1'b1;
                            r_instr_ready   <= 1'b0;
                            r_cnt           <= '0;
                            r_state         <= S_ISSUE;
                        end else begin
                            r_illegal_instr <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (op_done) begin
                        r_instr_ready <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // op_done wins over expiry in the final WAIT cycle.
                    if (op_done) begin
                        r_instr_ready <= 1'b1;
                        r_state       <= S_IDLE;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_instr_ready <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_instr_ready <= 1'b0;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_ready   = r_instr_ready;
    assign rs_addr_valid = r_rs_addr_valid;
    assign rs1_rs2_rd    = r_rs1_rs2_rd;
    assign imme_data     = r_imme_data;
    assign use_imm       = r_use_imm;
    assign rs_store      = r_rs_store;
    assign rd_wr_en      = r_rd_wr_en;
    assign alu_op        = r_alu_op;
    assign illegal_instr = r_illegal_instr;
    assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_instr_decode_issue.sv
module tb_instr_decode_issue;

    localparam int TMO = 16;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic        instr_ready;
    logic        rs_addr_valid;
    logic [14:0] rs1_rs2_rd;
    logic [31:0] imme_data;
    logic        use_imm;
    logic        rs_store;
    logic        rd_wr_en;
    logic [3:0]  alu_op;
    logic        op_done;
    logic        illegal_instr;
    logic        timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    instr_decode_issue #(
        .BUS_WIDTH      (32),
        .ADDR_WIDTH     (15),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr_data    (instr_data),
        .instr_ready   (instr_ready),
        .rs_addr_valid (rs_addr_valid),
        .rs1_rs2_rd    (rs1_rs2_rd),
        .imme_data     (imme_data),
        .use_imm       (use_imm),
        .rs_store      (rs_store),
        .rd_wr_en      (rd_wr_en),
        .alu_op        (alu_op),
        .op_done       (op_done),
        .illegal_instr (illegal_instr),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference decode from the ISA rules ----------------
    typedef struct packed {
        logic        legal;
        logic [14:0] rrr;
        logic [31:0] imm;
        logic        use_imm;
        logic        store;
        logic        wr;
        logic [3:0]  alu;
    } dec_t;

    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t d;
        int   s, rd, rs1, rs2;
        bit   has_rd, has_rs1, has_rs2;
        d = '0;
        d.legal = 1'b1;
        s   = int'($signed(w));
        rd  = int'(w[11:7]);
        rs1 = int'(w[19:15]);
        rs2 = int'(w[24:20]);
        has_rd = 0; has_rs1 = 0; has_rs2 = 0;
        case (w[6:0])
            7'b0110011: begin
                has_rd = 1; has_rs1 = 1; has_rs2 = 1;
                d.alu = {w[30], w[14:12]};
            end
            7'b0010011: begin
                has_rd = 1; has_rs1 = 1;
                d.imm = 32'(s >>> 20);
                d.use_imm = 1'b1;
                d.alu = (w[14:12] == 3'b101) ? {w[30], w[14:12]} : {1'b0, w[14:12]};
            end
            7'b0000011, 7'b1100111: begin
                has_rd = 1; has_rs1 = 1;
                d.imm = 32'(s >>> 20);
                d.use_imm = 1'b1;
            end
            7'b0100011: begin
                has_rs1 = 1; has_rs2 = 1;
                d.imm = 32'((s >>> 25) * 32 + int'(w[11:7]));
                d.use_imm = 1'b1;
                d.store = 1'b1;
            end
            7'b1100011: begin
                has_rs1 = 1; has_rs2 = 1;
                d.imm = 32'((s >>> 31) * 4096 + int'(w[7]) * 2048 +
                            int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
                d.alu = 4'd8;
            end
            7'b0110111, 7'b0010111: begin
                has_rd = 1;
                d.imm = w & 32'hFFFFF000;
                d.use_imm = 1'b1;
            end
            7'b1101111: begin
                has_rd = 1;
                d.imm = 32'((s >>> 31) * 1048576 + int'(w[19:12]) * 4096 +
                            int'(w[20]) * 2048 + int'(w[30:21]) * 2);
                d.use_imm = 1'b1;
            end
            default: d.legal = 1'b0;
        endcase
        d.rrr = 15'((has_rd ? rd : 0) * 1024 + (has_rs2 ? rs2 : 0) * 32 + (has_rs1 ? rs1 : 0));
        d.wr  = has_rd && (rd != 0);
        return d;
    endfunction

    // ---------------- transaction-level model ----------------
    // busy: an operation is outstanding; age: 0 in its issue cycle, k in the
    // k-th cycle spent waiting for the acknowledge.
    bit   m_init = 0;
    bit   m_ready, m_valid, m_illegal, m_timeout, m_busy;
    int   m_age;
    dec_t m_f;
    dec_t m_d;

    always @(posedge clk) begin
        if (rst) begin
            m_ready = 0; m_valid = 0; m_illegal = 0; m_timeout = 0;
            m_busy = 0; m_age = 0; m_f = '0;
        end else begin
            m_valid = 0;
            m_illegal = 0;
            if (!m_busy) begin
                if (m_ready && instr_valid) begin
                    m_d = ref_decode(instr_data);
                    if (m_d.legal) begin
                        m_f = m_d; m_busy = 1; m_age = 0; m_valid = 1; m_ready = 0;
                    end else begin
                        m_illegal = 1;
                    end
                end else begin
                    m_ready = 1;
                end
            end else begin
                if (op_done) begin
                    m_busy = 0; m_ready = 1;
                end else if (m_age == TMO) begin
                    m_timeout = 1; m_busy = 0; m_ready = 1;
                end else begin
                    m_age++;
                end
            end
        end
        m_init = 1;
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("instr_ready",   instr_ready,   m_ready);
            chk("rs_addr_valid", rs_addr_valid, m_valid);
            chk("illegal_instr", illegal_instr, m_illegal);
            chk("timeout_err",   timeout_err,   m_timeout);
            chk("rs1_rs2_rd",    rs1_rs2_rd,    m_f.rrr);
            chk("imme_data",     imme_data,     m_f.imm);
            chk("use_imm",       use_imm,       m_f.use_imm);
            chk("rs_store",      rs_store,      m_f.store);
            chk("rd_wr_en",      rd_wr_en,      m_f.wr);
            chk("alu_op",        alu_op,        m_f.alu);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Present instr once ready; returns in the cycle after acceptance.
    task automatic send(input logic [31:0] instr);
        int guard = 0;
        while (!instr_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!instr_ready) chk("send_ready_wait", {31'b0, instr_ready}, 32'd1);
        instr_valid = 1'b1;
        instr_data  = instr;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    // Acknowledge in wait cycle d (d=0: during the issue cycle).
    task automatic finish(input int d, input logic [14:0] rrr);
        for (int i = 1; i <= d; i++) begin
            @(negedge clk);
            chk("wait_ready", {31'b0, instr_ready}, 32'd0);
            chk("wait_issue", {31'b0, rs_addr_valid}, 32'd0);
            chk("wait_hold",  {17'b0, rs1_rs2_rd}, {17'b0, rrr});
        end
        op_done = 1'b1;
        @(negedge clk);
        op_done = 1'b0;
        chk("done_ready", {31'b0, instr_ready}, 32'd1);
    endtask

    task automatic run_op(input logic [31:0] instr, input logic [14:0] rrr,
                          input logic [31:0] imm, input logic ui, input logic st,
                          input logic wr, input logic [3:0] alu, input int d);
        send(instr);
        chk("lit_issue",   {31'b0, rs_addr_valid}, 32'd1);
        chk("lit_rrr",     {17'b0, rs1_rs2_rd}, {17'b0, rrr});
        chk("lit_imm",     imme_data, imm);
        chk("lit_use_imm", {31'b0, use_imm}, {31'b0, ui});
        chk("lit_store",   {31'b0, rs_store}, {31'b0, st});
        chk("lit_wr_en",   {31'b0, rd_wr_en}, {31'b0, wr});
        chk("lit_alu",     {28'b0, alu_op}, {28'b0, alu});
        finish(d, rrr);
    endtask

    logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                                  7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                                  7'b1101111};

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 7) != 0) w[6:0] = legal_ops[$urandom_range(0, 8)];
        return w;
    endfunction

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr_data = '0; op_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, instr_ready}, 32'd0);
        chk("rst_issue", {31'b0, rs_addr_valid}, 32'd0);
        chk("rst_rrr",   {17'b0, rs1_rs2_rd}, 32'd0);
        chk("rst_imm",   imme_data, 32'd0);
        chk("rst_tmo",   {31'b0, timeout_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'b0, instr_ready}, 32'd1);

        // ADD x3,x1,x2
        run_op(32'h002081B3, 15'h0C41, 32'h0, 1'b0, 1'b0, 1'b1, 4'h0, 0);
        @(negedge clk);
        chk("issue_one_cycle", {31'b0, rs_addr_valid}, 32'd0);
        // ADDI x5,x0,-1
        run_op(32'hFFF00293, 15'h1400, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 4'h0, 2);
        // SW x2,8(x1)
        run_op(32'h0020A423, 15'h0041, 32'h00000008, 1'b1, 1'b1, 1'b0, 4'h0, 1);
        // BEQ x1,x2,-4
        run_op(32'hFE208EE3, 15'h0041, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 4'h8, 0);
        // ADDI x0,x0,0
        run_op(32'h00000013, 15'h0000, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0, 0);
        // SRAI x7,x6,3 : alu takes bit 30
        run_op(32'h40335393, 15'h1C06, 32'h00000403, 1'b1, 1'b0, 1'b1, 4'hD, 0);

        // Illegal opcode: one-cycle pulse, no issue, fields unchanged
        send(32'h00000000);
        chk("illegal_pulse", {31'b0, illegal_instr}, 32'd1);
        chk("illegal_noissue", {31'b0, rs_addr_valid}, 32'd0);
        chk("illegal_hold", {17'b0, rs1_rs2_rd}, 32'h1C06);
        @(negedge clk);
        chk("illegal_clear", {31'b0, illegal_instr}, 32'd0);

        // Acknowledge in the final allowed wait cycle counts as completion
        run_op(32'h002081B3, 15'h0C41, 32'h0, 1'b0, 1'b0, 1'b1, 4'h0, TMO);
        chk("boundary_no_tmo", {31'b0, timeout_err}, 32'd0);

        // Backpressure with instr_valid held high
        instr_valid = 1'b1;
        instr_data  = 32'h002081B3;
        @(negedge clk);
        instr_data  = 32'hFFF00293;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_ready", {31'b0, instr_ready}, 32'd0);
            chk("bp_hold",  {17'b0, rs1_rs2_rd}, 32'h0C41);
        end
        op_done = 1'b1;
        @(negedge clk);
        op_done = 1'b0;
        chk("bp_ready_back", {31'b0, instr_ready}, 32'd1);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("bp_next_issue", {31'b0, rs_addr_valid}, 32'd1);
        chk("bp_next_rrr", {17'b0, rs1_rs2_rd}, 32'h1400);
        finish(0, 15'h1400);

        // Watchdog expiry
        send(32'h0020A423);
        repeat (TMO) @(negedge clk);
        chk("tmo_not_yet", {31'b0, timeout_err}, 32'd0);
        @(negedge clk);
        chk("tmo_set", {31'b0, timeout_err}, 32'd1);
        chk("tmo_ready", {31'b0, instr_ready}, 32'd1);
        run_op(32'h002081B3, 15'h0C41, 32'h0, 1'b0, 1'b0, 1'b1, 4'h0, 1);
        chk("tmo_sticky", {31'b0, timeout_err}, 32'd1);

        // Reset in WAIT aborts cleanly
        send(32'hFE208EE3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tmo",   {31'b0, timeout_err}, 32'd0);
        chk("abort_ready", {31'b0, instr_ready}, 32'd0);
        chk("abort_rrr",   {17'b0, rs1_rs2_rd}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_idle", {31'b0, instr_ready}, 32'd1);

        // Randomized traffic against the model
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            rst         = ($urandom_range(0, 299) == 0);
            instr_valid = ($urandom_range(0, 3) != 0);
            instr_data  = rand_instr();
            if ((c % 500) < 400) op_done = ($urandom_range(0, 2) == 0);
            else                 op_done = ($urandom_range(0, 39) == 0);
        end
        @(negedge clk);
        rst = 1'b0; instr_valid = 1'b0; op_done = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL sim_timeout: got stuck expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
